// File: rtl/id_stage_pkg.sv
// Shared types and constants for the LoongArch instruction-decode stage:
// bus widths, opcode encodings, forward-bus layout and the operand-forwarding helpers.
package id_stage_pkg;

  localparam int IF_TO_ID_W = 64;
  localparam int ID_TO_IF_W = 34;
  localparam int ID_TO_EX_W = 134;
  localparam int FWD_W      = 39;

  localparam logic [31:0] RESET_PC_NOP = 32'h0;

  // Major opcodes, inst[31:26]
  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  // Store opcodes, inst[31:22]
  localparam logic [9:0] OP_ST_B = 10'h0A4;
  localparam logic [9:0] OP_ST_H = 10'h0A5;
  localparam logic [9:0] OP_ST_W = 10'h0A6;

  // 1RI20 opcodes, inst[31:25]
  localparam logic [6:0] OP_LU12I     = 7'b0001010;
  localparam logic [6:0] OP_PCADDU12I = 7'b0001110;

  typedef enum logic [3:0] {
    BR_NONE, BR_JIRL, BR_B, BR_BL,
    BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } br_kind_e;

  // Forward bus from EX/MEM/WB: {valid, we, dest[4:0], result[31:0]}
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_to_id_t;

  typedef struct packed {
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_cancle;
  } id_to_if_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        rf_we;
  } id_to_ex_t;

  function automatic br_kind_e decode_br(input logic [5:0] op);
    case (op)
      OP_JIRL: return BR_JIRL;
      OP_B:    return BR_B;
      OP_BL:   return BR_BL;
      OP_BEQ:  return BR_BEQ;
      OP_BNE:  return BR_BNE;
      OP_BLT:  return BR_BLT;
      OP_BGE:  return BR_BGE;
      OP_BLTU: return BR_BLTU;
      OP_BGEU: return BR_BGEU;
      default: return BR_NONE;
    endcase
  endfunction

  function automatic logic is_cond_br(input br_kind_e k);
    return k inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
  endfunction

  function automatic logic fwd_hit(input fwd_t f, input logic [4:0] addr);
    return f.valid && f.we && (f.dest == addr) && (addr != 5'd0);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB, then the register file.
  function automatic logic [31:0] fwd_select(input logic [4:0]  addr,
                                             input logic [31:0] rf_data,
                                             input fwd_t        ex,
                                             input fwd_t        mem,
                                             input fwd_t        wb);
    if (addr == 5'd0)       return 32'h0;
    if (fwd_hit(ex, addr))  return ex.result;
    if (fwd_hit(mem, addr)) return mem.result;
    if (fwd_hit(wb, addr))  return wb.result;
    return rf_data;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Pipeline handshake between fetch, decode and execute as seen around the ID stage.
// The slave modport is the ID stage itself; master is the surrounding pipeline.
interface id_stage_if
  import id_stage_pkg::*;
();

  logic                  if_to_id_valid;
  logic [IF_TO_ID_W-1:0] if_to_id_bus;
  logic                  id_allow_in;
  logic [ID_TO_IF_W-1:0] id_to_if_bus;
  logic                  id_to_ex_valid;
  logic                  ex_allow_in;
  logic [ID_TO_EX_W-1:0] id_to_ex_bus;

  modport slave (
    input  if_to_id_valid, if_to_id_bus, ex_allow_in,
    output id_allow_in, id_to_if_bus, id_to_ex_valid, id_to_ex_bus
  );

  modport master (
    output if_to_id_valid, if_to_id_bus, ex_allow_in,
    input  id_allow_in, id_to_if_bus, id_to_ex_valid, id_to_ex_bus
  );

endinterface

// File: rtl/id_stage_branch.sv
// Branch resolution for the ID stage: condition compare, target adder, taken decision.
// Purely combinational; the caller qualifies br_cond with valid and stall.
module id_branch_unit
  import id_stage_pkg::*;
(
  input  br_kind_e    br_kind,
  input  logic [31:0] pc,
  input  logic [25:0] offs,
  input  logic [31:0] rj_val,
  input  logic [31:0] rd_val,
  output logic        br_cond,
  output logic [31:0] br_target
);

  logic [31:0] offs16_sext;
  logic [31:0] offs26_sext;
  logic        eq;
  logic        lt_s;
  logic        lt_u;

  // offs16 lives in inst[25:10]; offs26 puts its high 10 bits in inst[9:0].
  assign offs16_sext = {{14{offs[25]}}, offs[25:10], 2'b00};
  assign offs26_sext = {{4{offs[9]}}, offs[9:0], offs[25:10], 2'b00};

  assign eq   = (rj_val == rd_val);
  assign lt_s = ($signed(rj_val) < $signed(rd_val));
  assign lt_u = (rj_val < rd_val);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    br_cond   = 1'b0;
    br_target = pc + offs16_sext;
    case (br_kind)
      BR_JIRL: begin
        br_cond   = 1'b1;
        br_target = rj_val + offs16_sext;
      end
      BR_B, BR_BL: begin
        br_cond   = 1'b1;
        br_target = pc + offs26_sext;
      end
      BR_BEQ:  br_cond = eq;
      BR_BNE:  br_cond = !eq;
      BR_BLT:  br_cond = lt_s;
      BR_BGE:  br_cond = !lt_s;
      BR_BLTU: br_cond = lt_u;
      BR_BGEU: br_cond = !lt_u;
      default: br_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// LoongArch instruction-decode stage: latches the fetch bus, reads the regfile,
// forwards from EX/MEM/WB, stalls on load-use, resolves branches and feeds EX.
module id_stage
  import id_stage_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  id_stage_if.slave        pipe,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  input  logic [FWD_W-1:0] ex_fwd,
  input  logic [FWD_W-1:0] mem_fwd,
  input  logic [FWD_W-1:0] wb_fwd,
  input  logic             ex_is_load
);

  logic        id_valid_q, id_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  fwd_t        ex_f, mem_f, wb_f;
  if_to_id_t   fetch;
  br_kind_e    br_kind;
  logic [4:0]  rj, rk, rd;
  logic        is_store, is_cond, is_link, is_3r, is_lu12i, is_pcaddu12i;
  logic        use_src1, use_src2;
  logic [31:0] rj_val, r2_val;
  logic [31:0] src1, src2;
  logic [4:0]  dest;
  logic        rf_we;
  logic        load_use;
  logic        id_ready_go;
  logic        id_allow_in;
  logic        id_to_ex_valid;
  logic        br_cond;
  logic        br_taken;
  logic        br_fire;
  logic [31:0] br_target;

  assign ex_f  = fwd_t'(ex_fwd);
  assign mem_f = fwd_t'(mem_fwd);
  assign wb_f  = fwd_t'(wb_fwd);
  assign fetch = if_to_id_t'(pipe.if_to_id_bus);

  assign rj = inst_q[9:5];
  assign rk = inst_q[14:10];
  assign rd = inst_q[4:0];

  always_comb begin
    br_kind      = decode_br(inst_q[31:26]);
    is_cond      = is_cond_br(br_kind);
    is_link      = (br_kind == BR_BL) || (br_kind == BR_JIRL);
    is_store     = inst_q[31:22] inside {OP_ST_B, OP_ST_H, OP_ST_W};
    is_3r        = (inst_q[31:22] == 10'h000) && (inst_q[21:20] != 2'b00);
    is_lu12i     = (inst_q[31:25] == OP_LU12I);
    is_pcaddu12i = (inst_q[31:25] == OP_PCADDU12I);
    use_src1     = !((br_kind == BR_B) || (br_kind == BR_BL) || is_lu12i || is_pcaddu12i);
    use_src2     = is_3r || is_store || is_cond;
  end

  // Stores and conditional branches read rd as their second operand.
  assign rf_raddr1 = rj;
  assign rf_raddr2 = (is_store || is_cond) ? rd : rk;

  assign rj_val = fwd_select(rf_raddr1, rf_rdata1, ex_f, mem_f, wb_f);
  assign r2_val = fwd_select(rf_raddr2, rf_rdata2, ex_f, mem_f, wb_f);

  assign src1 = is_link ? (pc_q + 32'd4) : rj_val;
  assign src2 = is_link ? 32'h0 : r2_val;

  always_comb begin
    dest  = rd;
    rf_we = (rd != 5'd0);
    if (br_kind == BR_BL) begin
      dest  = 5'd1;
      rf_we = 1'b1;
    end else if (is_store || (br_kind == BR_B) || is_cond) begin
      dest  = 5'd0;
      rf_we = 1'b0;
    end
  end

  // A load in EX cannot forward yet; hold only if one of our live sources needs it.
  always_comb begin
    load_use = 1'b0;
    if (ex_f.valid && ex_f.we && ex_is_load) begin
      if (use_src1 && (rf_raddr1 != 5'd0) && (ex_f.dest == rf_raddr1)) load_use = 1'b1;
      if (use_src2 && (rf_raddr2 != 5'd0) && (ex_f.dest == rf_raddr2)) load_use = 1'b1;
    end
  end

  id_branch_unit u_branch (
    .br_kind   (br_kind),
    .pc        (pc_q),
    .offs      (inst_q[25:0]),
    .rj_val    (rj_val),
    .rd_val    (r2_val),
    .br_cond   (br_cond),
    .br_target (br_target)
  );

  assign id_ready_go    = !load_use;
  assign id_to_ex_valid = id_valid_q && id_ready_go;
  assign id_allow_in    = !id_valid_q || (id_ready_go && pipe.ex_allow_in);
  assign br_taken       = id_valid_q && id_ready_go && br_cond;
  assign br_fire        = br_taken && id_to_ex_valid && pipe.ex_allow_in;

  assign pipe.id_allow_in    = id_allow_in;
  assign pipe.id_to_ex_valid = id_to_ex_valid;
  assign pipe.id_to_if_bus   = id_to_if_t'{br_taken:  br_taken,
                                           br_target: br_target,
                                           br_cancle: br_taken};
  assign pipe.id_to_ex_bus   = id_to_ex_t'{pc:    pc_q,
                                           inst:  inst_q,
                                           src1:  src1,
                                           src2:  src2,
                                           dest:  dest,
                                           rf_we: rf_we};

  // The instruction arriving alongside a fired branch is wrong-path and is dropped.
  always_comb begin
    id_valid_d = id_valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    if (id_allow_in) begin
      id_valid_d = pipe.if_to_id_valid && !br_fire;
      if (pipe.if_to_id_valid) begin
        inst_d = fetch.inst;
        pc_d   = fetch.pc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid_q <= 1'b0;
      inst_q     <= RESET_PC_NOP;
      pc_q       <= 32'h0;
    end else begin
      id_valid_q <= id_valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage LoongArch pipeline; sits directly downstream of the fetch stage.
- Latches the {inst, pc} bus from fetch and reads the external register file.
- Resolves RAW hazards: forwards from EX/MEM/WB and stalls on load-use.
- Resolves branches in ID, returns redirect info to fetch, and hands operands plus dest info to EX under valid/allow_in handshake.

Parameters:
- IF_TO_ID_W, 64, fetch bus width {inst[31:0], pc[31:0]}
- ID_TO_IF_W, 34, redirect bus {br_taken, br_target[31:0], br_cancle}
- ID_TO_EX_W, 134, {pc, inst, src1, src2, dest[4:0], rf_we}
- RESET_PC_NOP, 32'h0, inst value held while invalid

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- if_to_id_valid  in  1  fetch output valid
- if_to_id_bus  in  64  {inst, pc}
- id_allow_in  out  1  ID can accept this cycle
- id_to_if_bus  out  34  {br_taken, br_target, br_cancle}
- id_to_ex_valid  out  1  ID hands instruction to EX
- ex_allow_in  in  1  EX can accept
- id_to_ex_bus  out  134  decoded payload
- rf_raddr1 / rf_raddr2  out  5 each  regfile read addresses
- rf_rdata1 / rf_rdata2  in  32 each  regfile read data (combinational)
- ex_fwd, mem_fwd, wb_fwd  in  39 each  {valid, we, dest[4:0], result[31:0]}
- ex_is_load  in  1  EX instruction is a load (result not yet available)

Behaviour:
- Async reset (resetn=0): id_valid=0, latched inst=0, latched pc=0; all outputs qualified by id_valid, so br_taken=0, br_cancle=0, id_to_ex_valid=0.
- Pipeline register: when id_allow_in=1, id_valid <= if_to_id_valid && !br_fire, and {inst, pc} <= if_to_id_bus if if_to_id_valid.
- id_allow_in = !id_valid || (id_ready_go && ex_allow_in); id_to_ex_valid = id_valid && id_ready_go; br_fire = br_taken && id_to_ex_valid && ex_allow_in.
- Sources: rj = inst[9:5], rk = inst[14:10], rd = inst[4:0].
  - rf_raddr1 = rj.
  - rf_raddr2 = rd for stores (st.b/h/w, inst[31:22] = 0x0A4/0x0A5/0x0A6) and for BEQ/BNE/BLT/BGE/BLTU/BGEU; otherwise rk.
- Source usage: src1 is used by all except B, BL, LU12I, PCADDU12I. src2 is used by 3R ALU ops, stores and conditional branches.
- Forwarding: per source, the first match of EX > MEM > WB, where match = valid && we && dest == addr && addr != 0; otherwise regfile data. r0 always reads 0.
- Load-use stall: id_ready_go = 0 when ex_fwd valid && we && ex_is_load && dest == a used nonzero source; cleared the cycle EX advances. No other stall.
- Dest:
  - BL writes r1.
  - Stores and B/BEQ..BGEU write nothing (rf_we=0).
  - All others write rd; rf_we forced 0 when dest == 0.
- Branch opcodes (inst[31:26]): JIRL 010011, B 010100, BL 010101, BEQ 010110, BNE 010111, BLT 011000, BGE 011001, BLTU 011010, BGEU 011011. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
- Branch targets:
  - B/BL: pc + sext({inst[9:0], inst[25:10], 2'b00}).
  - Conditional: pc + sext({inst[25:10], 2'b00}).
  - JIRL: src1 + sext({inst[25:10], 2'b00}).
  - BL/JIRL link value = pc+4, placed in src1 with src2 = 0.
- Redirect:
  - br_taken = id_valid && id_ready_go && condition true; br_cancle = br_taken.
  - Asserted combinationally only while stalled-free; fetch samples it only when its allow_in is high.
  - The instruction entering ID on br_fire is wrong-path and is discarded (id_valid <= 0).
- Stall with branch pending: br_taken stays 0 until the stall clears. No partial redirect.
- Back-pressure (ex_allow_in=0): register holds; br_taken may stay high, and fetch must not consume it until handoff.
- Reset mid-operation: immediate clear, no redirect issued.

Decomposition:
- Shared package/header: bus widths, opcode constants, forward-bus field offsets.
- One sub-module: id_branch_unit (comparator, target adder, taken decision; purely combinational).
- Forwarding mux and stall logic stay in id_stage.

Test Plan:
- Straight-line flow: inst add.w r3,r1,r2 @pc 0x1c000000, ex_allow_in=1 -> id_to_ex_valid next cycle, dest=3, rf_we=1, br_taken=0.
- Forward priority: EX and MEM both write r1 (0x11, 0x22) -> src1=0x11; EX invalid -> src1=0x22; dest r0 -> regfile value used.
- Load-use: ex_is_load, EX dest=r5, ID reads r5 -> id_ready_go=0 for 1 cycle, id_allow_in=0, then forwards from MEM.
- BEQ @0x1c000010, offs16=4, rj=rd=7 -> br_taken=1, br_target=0x1c000020, next inst from fetch dropped; rj≠rd -> no redirect.
- BL @0x1c000000 offs26=0x3FFFFFF -> target 0x1bfffffc, dest=1, src1=0x1c000004; JIRL r1+0 -> target=forwarded r1.
- resetn asserted low mid-stall -> id_valid=0, br_taken=0 the same cycle; no stale handoff after release.
